// File: rtl/int_ack_master.sv
// CPU-side interrupt acknowledge master: issues the two-pulse intackN handshake
// to the PIC, captures the vector from the shared bus and counts completed acks.
module int_ack_master #(
  parameter int unsigned PULSE_CYCLES   = 4,
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned HOLDOFF_CYCLES = 8
) (
  input  logic       MCLK,
  input  logic       reset,
  input  logic       enable,
  input  logic       int_in,
  input  logic [7:0] data_in,
  output logic       intackN,
  output logic [7:0] vector_out,
  output logic       vector_valid,
  output logic       busy,
  output logic [7:0] ack_count
);

  localparam logic [7:0] PULSE_LOAD   = 8'(PULSE_CYCLES - 1);
  localparam logic [7:0] GAP_LOAD     = 8'(GAP_CYCLES - 1);
  localparam logic [7:0] HOLDOFF_LOAD = 8'(HOLDOFF_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PULSE1  = 3'd1,
    S_GAP     = 3'd2,
    S_PULSE2  = 3'd3,
    S_HOLDOFF = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       intackn_q, intackn_d;
  logic [7:0] vector_q, vector_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;
  logic [7:0] count_q, count_d;

  // Next-state, counter and output computation; intackN is decided one edge
  // ahead so the registered pin changes on the same edge as the state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    intackn_d = intackn_q;
    vector_d  = vector_q;
    valid_d   = 1'b0;
    count_d   = count_q;
    case (state_q)
      S_IDLE: begin
        if (enable && int_in) begin
          state_d   = S_PULSE1;
          cnt_d     = PULSE_LOAD;
          intackn_d = 1'b0;
        end else begin
          cnt_d     = 8'd0;
          intackn_d = 1'b1;
        end
      end
      S_PULSE1: begin
        if (cnt_q == 8'd0) begin
          state_d   = S_GAP;
          cnt_d     = GAP_LOAD;
          intackn_d = 1'b1;
        end else begin
          cnt_d     = cnt_q - 8'd1;
          intackn_d = 1'b0;
        end
      end
      S_GAP: begin
        if (cnt_q == 8'd0) begin
          state_d   = S_PULSE2;
          cnt_d     = PULSE_LOAD;
          intackn_d = 1'b0;
        end else begin
          cnt_d     = cnt_q - 8'd1;
          intackn_d = 1'b1;
        end
      end
      S_PULSE2: begin
        // Capture edge: the bus carries the vector in the last pulse cycle.
        if (cnt_q == 8'd0) begin
          state_d   = S_HOLDOFF;
          cnt_d     = HOLDOFF_LOAD;
          intackn_d = 1'b1;
          vector_d  = data_in;
          valid_d   = 1'b1;
          if (count_q == 8'hFF) begin
            count_d = count_q;
          end else begin
            count_d = count_q + 8'd1;
          end
        end else begin
          cnt_d     = cnt_q - 8'd1;
          intackn_d = 1'b0;
        end
      end
      S_HOLDOFF: begin
        intackn_d = 1'b1;
        if (cnt_q == 8'd0) begin
          state_d = S_IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d   = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d   = S_IDLE;
        cnt_d     = 8'd0;
        intackn_d = 1'b1;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset forces intackN high immediately.
  always_ff @(posedge MCLK or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      intackn_q <= 1'b1;
      vector_q  <= 8'h00;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      count_q   <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      intackn_q <= intackn_d;
      vector_q  <= vector_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      count_q   <= count_d;
    end
  end

  assign intackN      = intackn_q;
  assign vector_out   = vector_q;
  assign vector_valid = valid_q;
  assign busy         = busy_q;
  assign ack_count    = count_q;

endmodule

// File: tb/tb_int_ack_master.sv
// Directed self-checking bench for int_ack_master: default timing instance plus
// a P=G=H=1 corner instance, with hand-derived expected waveforms.
module tb_int_ack_master;

  logic       MCLK = 1'b0;
  logic       reset;
  logic       enable, int_in;
  logic [7:0] data_in;
  logic       intack_n, vector_valid, busy;
  logic [7:0] vector_out, ack_count;

  logic       c_enable, c_int_in;
  logic [7:0] c_data_in;
  logic       c_intack_n, c_vector_valid, c_busy;
  logic [7:0] c_vector_out, c_ack_count;

  int n_checks = 0;
  int n_errors = 0;

  int_ack_master u_dut (
    .MCLK(MCLK), .reset(reset), .enable(enable), .int_in(int_in),
    .data_in(data_in), .intackN(intack_n), .vector_out(vector_out),
    .vector_valid(vector_valid), .busy(busy), .ack_count(ack_count)
  );

  int_ack_master #(.PULSE_CYCLES(1), .GAP_CYCLES(1), .HOLDOFF_CYCLES(1)) u_corner (
    .MCLK(MCLK), .reset(reset), .enable(c_enable), .int_in(c_int_in),
    .data_in(c_data_in), .intackN(c_intack_n), .vector_out(c_vector_out),
    .vector_valid(c_vector_valid), .busy(c_busy), .ack_count(c_ack_count)
  );

  always #5 MCLK = ~MCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected intackN level just after edge k of a sequence starting at edge 0.
  function automatic logic exp_ackn(input int k, input int p, input int g);
    return !((k >= 0 && k < p) || (k >= p + g && k < 2 * p + g));
  endfunction

  task automatic run_ack(input logic [7:0] vec, input bit drop, input logic [7:0] exp_cnt);
    enable  = 1'b1;
    int_in  = 1'b1;
    data_in = 8'hAA;
    for (int k = 0; k < 19; k++) begin
      @(posedge MCLK); #1;
      check("ack_n", {31'd0, intack_n}, {31'd0, exp_ackn(k, 4, 2)});
      check("busy", {31'd0, busy}, {31'd0, (k < 18)});
      check("valid", {31'd0, vector_valid}, {31'd0, (k == 10)});
      if (k == 10) begin
        check("vector", {24'd0, vector_out}, {24'd0, vec});
        check("count", {24'd0, ack_count}, {24'd0, exp_cnt});
      end
      if (k == 6) data_in = vec;
      if (k == 10) data_in = 8'hAA;
      if (drop && k == 4) int_in = 1'b0;
      if (!drop && k == 10) int_in = 1'b0;
    end
    check("vector_hold", {24'd0, vector_out}, {24'd0, vec});
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; int_in = 1'b0; data_in = 8'h00;
    c_enable = 1'b0; c_int_in = 1'b0; c_data_in = 8'h00;
    #1;
    check("rst_ack_n", {31'd0, intack_n}, 32'd1);
    check("rst_vector", {24'd0, vector_out}, 32'd0);
    check("rst_valid", {31'd0, vector_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_count", {24'd0, ack_count}, 32'd0);
    @(posedge MCLK); @(posedge MCLK); #1;
    reset = 1'b0;

    // Enable gating: pending interrupt but no permission to start.
    int_in = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(posedge MCLK); #1;
      check("gate_ack_n", {31'd0, intack_n}, 32'd1);
      check("gate_busy", {31'd0, busy}, 32'd0);
    end
    check("gate_count", {24'd0, ack_count}, 32'd0);

    // Enabling starts at the next edge; basic acknowledge of 8'h47.
    run_ack(8'h47, 1'b0, 8'd1);

    // int_in dropped during the gap still completes with a capture.
    run_ack(8'h40, 1'b1, 8'd2);

    // Reset during PULSE2.
    enable = 1'b1; int_in = 1'b1; data_in = 8'h99;
    for (int k = 0; k < 9; k++) begin
      @(posedge MCLK); #1;
    end
    check("pre_rst_ack_n", {31'd0, intack_n}, 32'd0);
    reset = 1'b1;
    #1;
    check("mid_rst_ack_n", {31'd0, intack_n}, 32'd1);
    check("mid_rst_vector", {24'd0, vector_out}, 32'd0);
    check("mid_rst_count", {24'd0, ack_count}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge MCLK); #1;
      check("mid_rst_valid", {31'd0, vector_valid}, 32'd0);
    end
    reset = 1'b0;
    run_ack(8'h5A, 1'b0, 8'd1);

    // Stuck interrupt: back-to-back sequences 19 cycles apart, count saturates.
    reset = 1'b1;
    @(posedge MCLK); #1;
    reset = 1'b0; enable = 1'b1; int_in = 1'b1; data_in = 8'hAA;
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < 19; k++) begin
        @(posedge MCLK); #1;
        if (k == 0) check("stuck_start", {31'd0, intack_n}, 32'd0);
        if (k == 6) data_in = 8'(i);
        if (k == 10) begin
          check("stuck_vector", {24'd0, vector_out}, {24'd0, 8'(i)});
          check("stuck_valid", {31'd0, vector_valid}, 32'd1);
        end
        if (k == 18) begin
          check("stuck_idle", {31'd0, busy}, 32'd0);
          check("stuck_count", {24'd0, ack_count}, (i >= 254) ? 32'd255 : 32'(i + 1));
        end
      end
    end
    int_in = 1'b0;
    @(posedge MCLK); #1;

    // Corner instance P=G=H=1: two sequences, second starting at edge 5.
    c_enable = 1'b1; c_int_in = 1'b1; c_data_in = 8'h11;
    for (int k = 0; k < 6; k++) begin
      @(posedge MCLK); #1;
      check("c_ack_n", {31'd0, c_intack_n}, {31'd0, exp_ackn((k < 5) ? k : k - 5, 1, 1)});
      check("c_busy", {31'd0, c_busy}, {31'd0, (k < 4 || k == 5)});
      check("c_valid", {31'd0, c_vector_valid}, {31'd0, (k == 3)});
      if (k == 3) begin
        check("c_vector", {24'd0, c_vector_out}, 32'h0000_00C3);
        check("c_count", {24'd0, c_ack_count}, 32'd1);
      end
      if (k == 2) c_data_in = 8'hC3;
      if (k == 3) c_data_in = 8'h11;
    end
    c_int_in = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/int_ack_master.md
# int_ack_master

Interrupt-acknowledge bus master that sits directly downstream of the `pic` block and plays the CPU side of the interrupt handshake. It watches the PIC's `int_out`, generates the two-pulse `intackN` sequence the PIC expects, and captures the vector the PIC drives onto the shared data bus during the second pulse. It then reports the vector with a one-cycle strobe. In `top_pic` it replaces the button-toggled `intackN` state machine, so the ROM sequencer and the display can run against a self-acknowledging interrupt path.

## Interface
- `PULSE_CYCLES`, 4: width of each `intackN` low pulse, in MCLK cycles (legal range 1..255).
- `GAP_CYCLES`, 2: `intackN` high time between the two pulses (legal range 1..255).
- `HOLDOFF_CYCLES`, 8: dead time after capture before a new interrupt is accepted (legal range 1..255).

- `MCLK` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `enable` in 1: permits starting a new acknowledge sequence; it has no effect on a sequence already in progress.
- `int_in` in 1: interrupt pending, driven by the PIC `int_out`; synchronous to MCLK.
- `data_in` in 8: shared data bus (`data_wire`), sampled only at the capture edge.
- `intackN` out 1: active-low acknowledge to the PIC; registered.
- `vector_out` out 8: last captured vector; holds its value until the next capture.
- `vector_valid` out 1: one-cycle strobe, high in the cycle after capture.
- `busy` out 1: high in every state other than IDLE.
- `ack_count` out 8: number of completed acknowledge sequences; saturates at 255.

## Operation
- States: IDLE, PULSE1, GAP, PULSE2, HOLDOFF. A single 8-bit down-counter `cnt` times every state except IDLE.
- **IDLE**
  - `intackN`=1.
  - If `enable`=1 and `int_in`=1 at an edge: go to PULSE1, load `cnt`=PULSE_CYCLES-1, and drive `intackN` 0 at that same edge.
- **PULSE1**
  - `intackN`=0.
  - At `cnt`=0: go to GAP, load `cnt`=GAP_CYCLES-1, drive `intackN` 1.
  - Otherwise decrement `cnt`.
- **GAP**
  - `intackN`=1.
  - At `cnt`=0: go to PULSE2, load `cnt`=PULSE_CYCLES-1, drive `intackN` 0.
- **PULSE2**
  - `intackN`=0.
  - At `cnt`=0 (the capture edge): `vector_out`<=`data_in`, `vector_valid`<=1, `ack_count`<=`ack_count`+1 unless already 255, `intackN`<=1.
  - Go to HOLDOFF and load `cnt`=HOLDOFF_CYCLES-1.
- **HOLDOFF**
  - `intackN`=1. `vector_valid` is cleared at the first edge after capture.
  - At `cnt`=0: go to IDLE.
- `int_in` is ignored outside IDLE. Dropping it mid-sequence does not abort the sequence: the PIC owns the consequences, and the sequence always completes with a capture.
- A stuck-high `int_in` with `enable`=1 produces back-to-back sequences, each separated by HOLDOFF plus one IDLE cycle.
- Dropping `enable` mid-sequence completes the current sequence and blocks the next start.
- An illegal state encoding returns to IDLE with `intackN`=1.
- Reset values:
  - state IDLE, `cnt`=0
  - `intackN`=1, `vector_out`=8'h00, `vector_valid`=0
  - `busy`=0, `ack_count`=8'h00

## Timing
- Edge numbering: edge 0 is the edge at which IDLE samples `enable`&`int_in`=1.
- `intackN` waveform:
  - low from edge 0 to edge P;
  - high from edge P to edge P+G;
  - low from edge P+G to edge 2P+G.
  - Here P=PULSE_CYCLES and G=GAP_CYCLES.
- Capture happens at edge 2P+G, sampling `data_in` on the last cycle of the second pulse. `vector_valid` is high for the single cycle [2P+G, 2P+G+1).
- `busy` is high from edge 0 to edge 2P+G+H, where H=HOLDOFF_CYCLES. The earliest next start is edge 2P+G+H+1.
- With defaults: pulses [0,4) and [6,10), capture at edge 10, IDLE at edge 18, next start no earlier than edge 19.
- Reset asserted mid-sequence forces `intackN` to 1 immediately (asynchronously) and discards the partial sequence; `vector_out` and `ack_count` are reset as well.
- Reset deasserting while `int_in`=1 starts a sequence at the first active edge where `enable`=1.

## Test plan
- **Basic acknowledge:** reset, `enable`=1, raise `int_in` before edge 0, PIC model drives `data_in`=8'h47 during the second pulse. Required: `intackN` low [0,4) and [6,10); `vector_out`=8'h47 and `vector_valid`=1 for exactly one cycle after edge 10; `ack_count`=1; `busy` falls at edge 18.
- **Enable gating:** `enable`=0 with `int_in`=1 held for 50 cycles. Required: `intackN` stays 1, `busy`=0, `ack_count`=0. Then raise `enable`: the sequence starts at the next edge.
- **Mid-sequence drop:** `int_in` drops during the gap, with `data_in`=8'h40 in the second pulse. Required: the full two-pulse waveform is still produced and `vector_out`=8'h40 is captured.
- **Reset during PULSE2:** assert `reset` at cycle 8. Required: `intackN`=1 within the same cycle, `vector_out`=8'h00, `ack_count`=0, no `vector_valid`. After release with `int_in`=1, a clean sequence starts.
- **Stuck interrupt and saturation:** `int_in`=1 held for 300 sequences, with `data_in` incrementing per sequence. Required: sequence starts 19 cycles apart; `vector_out` tracks the driven values; `ack_count` saturates at 255 and does not wrap.
- **Parameter corner:** P=1, G=1, H=1. Required: `intackN` low at [0,1) and [2,3); capture at edge 3; `vector_valid` at [3,4); next start no earlier than edge 5.
